// File: rtl/req_gnt_checker_if.sv
// req_gnt_checker_if
//   Groups the per-channel request/grant handshake of an arbiter so that
//   requesters, the arbiter and a passive protocol monitor can share one
//   bundle.
//
//   Parameters:
//     NUM_CH  number of req/gnt channel pairs
//
//   Signals:
//     req  [NUM_CH]  per-channel request, driven by the requester side
//     gnt  [NUM_CH]  per-channel grant, driven by the arbiter side
//
//   Modports:
//     master   requester view (drives req, observes gnt)
//     slave    arbiter view   (observes req, drives gnt)
//     monitor  passive view   (observes both, drives nothing)

interface req_gnt_checker_if #(
  parameter int NUM_CH = 4
);

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] gnt;

  modport master  (output req, input  gnt);
  modport slave   (input  req, output gnt);
  modport monitor (input  req, input  gnt);

endinterface

// File: rtl/req_gnt_checker.sv
// req_gnt_checker
//   Passive request/grant protocol monitor for NUM_CH independent channels.
//   Every channel must see its grant within 1..MAX_LAT cycles of the first
//   request cycle, must not withdraw its request before being granted, and
//   must not be granted while no request is pending. Optionally, no more than
//   one grant may be active in any cycle. Violations are reported as
//   registered one-cycle pulses, a sticky flag and a saturating counter. The
//   largest legal grant latency observed is also recorded.
//
//   Parameters:
//     NUM_CH       number of req/gnt channel pairs (1..32)
//     MAX_LAT      maximum allowed grant latency in cycles (>=1)
//     ONE_HOT_GNT  1 = flag any cycle with more than one gnt bit set
//     CNT_W        width of the error counter
//     LAT_W        derived width of latency fields, $clog2(MAX_LAT+1)
//
//   Ports:
//     clk           clock, all logic on posedge
//     res           synchronous active-high reset
//     bus           req/gnt bundle, monitor modport (inputs only)
//     err_timeout   [NUM_CH] pulse: grant latency exceeded MAX_LAT
//     err_spurious  [NUM_CH] pulse: grant with no pending request
//     err_drop      [NUM_CH] pulse: request withdrawn before grant
//     err_mutex     pulse: more than one grant bit in one cycle
//     err_sticky    set by any error pulse, cleared only by res
//     err_count     [CNT_W] saturating total of error pulses
//     lat_max       [LAT_W] largest in-bound grant latency seen
//
//   Build option:
//     REQ_GNT_CHK_ASSERT_EN  when defined, adds named concurrent assertions
//                            (timeout, spurious, drop, mutex) that issue
//                            $error with the channel index. The flag outputs
//                            behave identically with or without it.

module req_gnt_checker #(
  parameter  int NUM_CH      = 4,
  parameter  int MAX_LAT     = 4,
  parameter  int ONE_HOT_GNT = 1,
  parameter  int CNT_W       = 8,
  localparam int LAT_W       = $clog2(MAX_LAT + 1)
) (
  input  logic                    clk,
  input  logic                    res,
  req_gnt_checker_if.monitor      bus,
  output logic [NUM_CH-1:0]       err_timeout,
  output logic [NUM_CH-1:0]       err_spurious,
  output logic [NUM_CH-1:0]       err_drop,
  output logic                    err_mutex,
  output logic                    err_sticky,
  output logic [CNT_W-1:0]        err_count,
  output logic [LAT_W-1:0]        lat_max
);

  // Per-channel FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_LATE = 2'd2;

  // 7 bits covers one pulse per channel (32 max) plus the mutex pulse
  localparam int SUM_W = 7;

  localparam logic [LAT_W-1:0]       LAT_LIMIT = LAT_W'(MAX_LAT);
  localparam logic [CNT_W+SUM_W:0]   CNT_SAT   = {{(SUM_W+1){1'b0}}, {CNT_W{1'b1}}};

  logic [1:0]       state_q [NUM_CH];
  logic [1:0]       state_d [NUM_CH];
  logic [LAT_W-1:0] cnt_q   [NUM_CH];
  logic [LAT_W-1:0] cnt_d   [NUM_CH];

  logic [NUM_CH-1:0] err_timeout_q,  err_timeout_d;
  logic [NUM_CH-1:0] err_spurious_q, err_spurious_d;
  logic [NUM_CH-1:0] err_drop_q,     err_drop_d;
  logic [NUM_CH-1:0] complete;
  logic              err_mutex_q,    err_mutex_d;
  logic              err_sticky_q,   err_sticky_d;
  logic [CNT_W-1:0]  err_count_q,    err_count_d;
  logic [LAT_W-1:0]  lat_max_q,      lat_max_d;

  logic [SUM_W-1:0]       gnt_ones;
  logic [SUM_W-1:0]       pulse_sum;
  logic [CNT_W+SUM_W:0]   count_sum;

  // Channel FSMs. The counter holds the latency the request would have if
  // granted in the current cycle: it is 1 in the first cycle after the
  // request was first sampled. A grant in WAIT always counts as completion,
  // even when req drops in the same cycle, so completion is tested first.
  always_comb begin
    err_timeout_d  = '0;
    err_spurious_d = '0;
    err_drop_d     = '0;
    complete       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (bus.gnt[i]) begin
            err_spurious_d[i] = 1'b1;
          end else if (bus.req[i]) begin
            state_d[i] = ST_WAIT;
            cnt_d[i]   = LAT_W'(1);
          end
        end
        ST_WAIT: begin
          if (bus.gnt[i]) begin
            complete[i] = 1'b1;
            state_d[i]  = ST_IDLE;
            cnt_d[i]    = '0;
          end else if (!bus.req[i]) begin
            err_drop_d[i] = 1'b1;
            state_d[i]    = ST_IDLE;
            cnt_d[i]      = '0;
          end else if (cnt_q[i] == LAT_LIMIT) begin
            err_timeout_d[i] = 1'b1;
            state_d[i]       = ST_LATE;
          end else begin
            cnt_d[i] = cnt_q[i] + LAT_W'(1);
          end
        end
        ST_LATE: begin
          // Already reported; wait quietly for the transaction to end
          if (bus.gnt[i] || !bus.req[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Grant mutual exclusion, independent of the channel FSMs
  always_comb begin
    gnt_ones = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt_ones = gnt_ones + SUM_W'(bus.gnt[i]);
    end
    err_mutex_d = (ONE_HOT_GNT != 0) && (gnt_ones > SUM_W'(1));
  end

  // Summary state: largest completed latency, sticky flag and a counter
  // that adds every pulse of this cycle and clamps at all-ones.
  always_comb begin
    lat_max_d = lat_max_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (complete[i] && (cnt_q[i] > lat_max_d)) begin
        lat_max_d = cnt_q[i];
      end
    end

    pulse_sum = SUM_W'(err_mutex_d);
    for (int i = 0; i < NUM_CH; i++) begin
      pulse_sum = pulse_sum + SUM_W'(err_timeout_d[i])
                            + SUM_W'(err_spurious_d[i])
                            + SUM_W'(err_drop_d[i]);
    end

    count_sum = {{(SUM_W+1){1'b0}}, err_count_q} + {{(CNT_W+1){1'b0}}, pulse_sum};
    if (count_sum > CNT_SAT) begin
      err_count_d = {CNT_W{1'b1}};
    end else begin
      err_count_d = count_sum[CNT_W-1:0];
    end

    err_sticky_d = err_sticky_q | (pulse_sum != '0);
  end

  // A reset abandons any open transaction without reporting it
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      err_timeout_q  <= '0;
      err_spurious_q <= '0;
      err_drop_q     <= '0;
      err_mutex_q    <= 1'b0;
      err_sticky_q   <= 1'b0;
      err_count_q    <= '0;
      lat_max_q      <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      err_timeout_q  <= err_timeout_d;
      err_spurious_q <= err_spurious_d;
      err_drop_q     <= err_drop_d;
      err_mutex_q    <= err_mutex_d;
      err_sticky_q   <= err_sticky_d;
      err_count_q    <= err_count_d;
      lat_max_q      <= lat_max_d;
    end
  end

  assign err_timeout  = err_timeout_q;
  assign err_spurious = err_spurious_q;
  assign err_drop     = err_drop_q;
  assign err_mutex    = err_mutex_q;
  assign err_sticky   = err_sticky_q;
  assign err_count    = err_count_q;
  assign lat_max      = lat_max_q;

`ifdef REQ_GNT_CHK_ASSERT_EN
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sva
    property p_no_timeout;
      @(posedge clk) disable iff (res) !err_timeout_d[gi];
    endproperty
    property p_no_spurious;
      @(posedge clk) disable iff (res) !err_spurious_d[gi];
    endproperty
    property p_no_drop;
      @(posedge clk) disable iff (res) !err_drop_d[gi];
    endproperty

    a_timeout: assert property (p_no_timeout)
      else $error("req_gnt_checker: grant timeout on channel %0d", gi);
    a_spurious: assert property (p_no_spurious)
      else $error("req_gnt_checker: spurious grant on channel %0d", gi);
    a_drop: assert property (p_no_drop)
      else $error("req_gnt_checker: request dropped on channel %0d", gi);
  end

  property p_no_mutex;
    @(posedge clk) disable iff (res) !err_mutex_d;
  endproperty

  a_mutex: assert property (p_no_mutex)
    else $error("req_gnt_checker: multiple grants, gnt=%b", bus.gnt);
`endif

endmodule

// File: tb/tb_req_gnt_checker.sv
// tb_req_gnt_checker
//   Self-checking bench for req_gnt_checker. Two checkers watch the same
//   req/gnt bundle: one with an 8-bit error counter and one with a 2-bit
//   counter so saturation is exercised by the same traffic. Expected values
//   come from a timestamp-based reference model: each channel remembers the
//   cycle its request started, and latency is simply the difference of cycle
//   numbers. A directed sequence walks the documented scenarios, then
//   random traffic (with occasional resets) follows.

module tb_req_gnt_checker;

  localparam int NUM_CH  = 4;
  localparam int MAX_LAT = 4;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);
  localparam int CNT_MAX = 255;
  localparam int SAT_MAX = 3;

  logic clk;
  logic res;

  req_gnt_checker_if #(.NUM_CH(NUM_CH)) rg_if ();

  logic [NUM_CH-1:0] err_timeout, err_spurious, err_drop;
  logic              err_mutex, err_sticky;
  logic [7:0]        err_count;
  logic [LAT_W-1:0]  lat_max;

  logic [NUM_CH-1:0] sat_timeout, sat_spurious, sat_drop;
  logic              sat_mutex, sat_sticky;
  logic [1:0]        sat_count;
  logic [LAT_W-1:0]  sat_lat_max;

  req_gnt_checker #(
    .NUM_CH(NUM_CH), .MAX_LAT(MAX_LAT), .ONE_HOT_GNT(1), .CNT_W(8)
  ) u_dut (
    .clk(clk), .res(res), .bus(rg_if),
    .err_timeout(err_timeout), .err_spurious(err_spurious), .err_drop(err_drop),
    .err_mutex(err_mutex), .err_sticky(err_sticky), .err_count(err_count),
    .lat_max(lat_max)
  );

  req_gnt_checker #(
    .NUM_CH(NUM_CH), .MAX_LAT(MAX_LAT), .ONE_HOT_GNT(1), .CNT_W(2)
  ) u_dut_sat (
    .clk(clk), .res(res), .bus(rg_if),
    .err_timeout(sat_timeout), .err_spurious(sat_spurious), .err_drop(sat_drop),
    .err_mutex(sat_mutex), .err_sticky(sat_sticky), .err_count(sat_count),
    .lat_max(sat_lat_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int                cyc = 0;
  int                pend_start [NUM_CH];
  bit                late_flag  [NUM_CH];
  logic [NUM_CH-1:0] exp_timeout, exp_spurious, exp_drop;
  logic              exp_mutex, exp_sticky;
  int                exp_count, exp_count_sat, exp_lat_max;

  task automatic model_step(input logic r_res, input logic [NUM_CH-1:0] r_req,
                            input logic [NUM_CH-1:0] r_gnt);
    int lat;
    int errs;
    exp_timeout  = '0;
    exp_spurious = '0;
    exp_drop     = '0;
    exp_mutex    = 1'b0;
    if (r_res) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pend_start[i] = -1;
        late_flag[i]  = 1'b0;
      end
      exp_sticky    = 1'b0;
      exp_count     = 0;
      exp_count_sat = 0;
      exp_lat_max   = 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (late_flag[i]) begin
          if (r_gnt[i] || !r_req[i]) late_flag[i] = 1'b0;
        end else if (pend_start[i] < 0) begin
          if (r_gnt[i])      exp_spurious[i] = 1'b1;
          else if (r_req[i]) pend_start[i] = cyc;
        end else begin
          lat = cyc - pend_start[i];
          if (r_gnt[i]) begin
            if (lat > exp_lat_max) exp_lat_max = lat;
            pend_start[i] = -1;
          end else if (!r_req[i]) begin
            exp_drop[i]   = 1'b1;
            pend_start[i] = -1;
          end else if (lat == MAX_LAT) begin
            exp_timeout[i] = 1'b1;
            late_flag[i]   = 1'b1;
            pend_start[i]  = -1;
          end
        end
      end
      exp_mutex = ($countones(r_gnt) > 1);
      errs = $countones(exp_timeout) + $countones(exp_spurious)
           + $countones(exp_drop) + int'(exp_mutex);
      exp_count     = (exp_count + errs > CNT_MAX) ? CNT_MAX : exp_count + errs;
      exp_count_sat = (exp_count_sat + errs > SAT_MAX) ? SAT_MAX : exp_count_sat + errs;
      if (errs != 0) exp_sticky = 1'b1;
    end
    cyc++;
  endtask

  task automatic check_val(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive inputs away from the sampling edge, let the model see the same
  // values the DUT samples, and leave time for outputs to settle.
  task automatic applyStimulus(input logic r_res, input logic [NUM_CH-1:0] r_req,
                               input logic [NUM_CH-1:0] r_gnt);
    @(negedge clk);
    res       = r_res;
    rg_if.req = r_req;
    rg_if.gnt = r_gnt;
    @(posedge clk);
    model_step(r_res, r_req, r_gnt);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check_val({tag, ":timeout"},  32'(err_timeout),  32'(exp_timeout));
    check_val({tag, ":spurious"}, 32'(err_spurious), 32'(exp_spurious));
    check_val({tag, ":drop"},     32'(err_drop),     32'(exp_drop));
    check_val({tag, ":mutex"},    32'(err_mutex),    32'(exp_mutex));
    check_val({tag, ":sticky"},   32'(err_sticky),   32'(exp_sticky));
    check_val({tag, ":count"},    32'(err_count),    32'(exp_count));
    check_val({tag, ":lat_max"},  32'(lat_max),      32'(exp_lat_max));
    check_val({tag, ":sat_count"}, 32'(sat_count),   32'(exp_count_sat));
    check_val({tag, ":sat_flags"},
              32'({sat_timeout, sat_spurious, sat_drop, sat_mutex, sat_sticky, sat_lat_max}),
              32'({exp_timeout, exp_spurious, exp_drop, exp_mutex, exp_sticky, LAT_W'(exp_lat_max)}));
  endtask

  task automatic step(input string tag, input logic r_res,
                      input logic [NUM_CH-1:0] r_req, input logic [NUM_CH-1:0] r_gnt);
    applyStimulus(r_res, r_req, r_gnt);
    checkOutput(tag);
  endtask

  initial begin
    logic [NUM_CH-1:0] r_req;
    logic [NUM_CH-1:0] r_gnt;
    logic              r_res;

    res       = 1'b1;
    rg_if.req = '0;
    rg_if.gnt = '0;

    // Reset state
    step("reset0", 1'b1, 4'b0000, 4'b0000);
    step("reset1", 1'b1, 4'b0000, 4'b0000);

    // ch0 request at edge 0, grant at edge 3: latency 3, no error
    step("lat3_e0", 1'b0, 4'b0001, 4'b0000);
    step("lat3_e1", 1'b0, 4'b0001, 4'b0000);
    step("lat3_e2", 1'b0, 4'b0001, 4'b0000);
    step("lat3_e3", 1'b0, 4'b0001, 4'b0001);
    check_val("plan_lat3_latmax", 32'(lat_max),   32'd3);
    check_val("plan_lat3_count",  32'(err_count), 32'd0);
    step("idle_a", 1'b0, 4'b0000, 4'b0000);

    // ch1 held with no grant: single timeout after edge 4, grant at edge 7
    for (int e = 0; e < 5; e++) step("tmo_wait", 1'b0, 4'b0010, 4'b0000);
    check_val("plan_tmo_pulse", 32'(err_timeout), 32'h2);
    step("tmo_e5", 1'b0, 4'b0010, 4'b0000);
    check_val("plan_tmo_once", 32'(err_timeout), 32'h0);
    step("tmo_e6", 1'b0, 4'b0010, 4'b0000);
    step("tmo_e7", 1'b0, 4'b0010, 4'b0010);
    check_val("plan_tmo_latmax", 32'(lat_max), 32'd3);
    step("idle_b", 1'b0, 4'b0000, 4'b0000);

    // Spurious grant on idle ch2
    step("spur", 1'b0, 4'b0000, 4'b0100);
    check_val("plan_spur_flag", 32'(err_spurious), 32'h4);

    // ch0 request dropped at latency 2
    step("drop_e0", 1'b0, 4'b0001, 4'b0000);
    step("drop_e1", 1'b0, 4'b0001, 4'b0000);
    step("drop_e2", 1'b0, 4'b0000, 4'b0000);
    check_val("plan_drop_flag", 32'(err_drop), 32'h1);

    // Two waiting channels granted together: mutex only
    step("mtx_e0", 1'b0, 4'b0101, 4'b0000);
    step("mtx_e1", 1'b0, 4'b0101, 4'b0000);
    step("mtx_e2", 1'b0, 4'b0101, 4'b0101);
    step("idle_c", 1'b0, 4'b0000, 4'b0000);

    // Three simultaneous errors: two spurious plus mutex
    step("multi", 1'b0, 4'b0000, 4'b0011);
    check_val("plan_sat_count", 32'(sat_count), 32'd3);
    step("idle_d", 1'b0, 4'b0000, 4'b0000);

    // Back-to-back requests on ch3; grant with req low still completes
    step("b2b_e0", 1'b0, 4'b1000, 4'b0000);
    step("b2b_e1", 1'b0, 4'b1000, 4'b1000);
    step("b2b_e2", 1'b0, 4'b1000, 4'b0000);
    step("b2b_e3", 1'b0, 4'b0000, 4'b1000);
    step("idle_e", 1'b0, 4'b0000, 4'b0000);

    // Reset while ch3 waits, then a clean latency-1 transaction
    step("rst_e0", 1'b0, 4'b1000, 4'b0000);
    step("rst_e1", 1'b0, 4'b1000, 4'b0000);
    for (int e = 0; e < 3; e++) step("rst_hold", 1'b1, 4'b1000, 4'b0000);
    check_val("plan_rst_count", 32'(err_count), 32'd0);
    step("rst_rel", 1'b0, 4'b0000, 4'b0000);
    step("fresh_e0", 1'b0, 4'b1000, 4'b0000);
    step("fresh_e1", 1'b0, 4'b1000, 4'b1000);
    check_val("plan_fresh_latmax", 32'(lat_max), 32'd1);
    for (int e = 0; e < 6; e++) step("quiet", 1'b0, 4'b0000, 4'b0000);

    // Random traffic: sticky requests, grants mostly to requesters
    r_req = '0;
    for (int n = 0; n < 600; n++) begin
      r_res = ($urandom_range(0, 149) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if (!r_req[c] && $urandom_range(0, 3) == 0)      r_req[c] = 1'b1;
        else if (r_req[c] && $urandom_range(0, 9) == 0)  r_req[c] = 1'b0;
        r_gnt[c] = r_req[c] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
      end
      step("rand", r_res, r_req, r_gnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/req_gnt_checker.md
# req_gnt_checker

Parametrised, synthesizable request/grant protocol monitor for NUM_CH independent channels; generalises the single-channel "req |=> gnt" check to a bounded grant latency window, adding request-withdrawal, spurious-grant and grant-mutex checks. Attached to an arbiter or DUT instance through `bind` (passive, inputs only) or instantiated directly in the testbench top. It reports violations as registered flag pulses and counters that a bench or debug register can read. With MAX_LAT=1 and ONE_HOT_GNT=0 it is functionally the original single-cycle req/gnt check per channel.

## Interface
- NUM_CH, 4: number of req/gnt channel pairs (1..32)
- MAX_LAT, 4: maximum allowed grant latency in cycles (>=1)
- ONE_HOT_GNT, 1: 1 = flag any cycle with more than one gnt bit set
- CNT_W, 8: width of error counter
- LAT_W, $clog2(MAX_LAT+1): width of latency fields (derived, not overridden)
---
- clk  in  1  clock; all logic on posedge
- res  in  1  synchronous, active-high reset
- req  in  NUM_CH  per-channel request
- gnt  in  NUM_CH  per-channel grant
- err_timeout  out  NUM_CH  pulse: latency exceeded MAX_LAT
- err_spurious  out  NUM_CH  pulse: gnt with no pending request
- err_drop  out  NUM_CH  pulse: req deasserted before gnt
- err_mutex  out  1  pulse: >1 gnt bit in one cycle
- err_sticky  out  1  set by any error pulse, cleared only by res
- err_count  out  CNT_W  saturating total of error pulses
- lat_max  out  LAT_W  largest in-bound grant latency seen

## Operation
- Per-channel FSM with LAT_W latency counter; states IDLE, WAIT, LATE.
- IDLE: req=1, gnt=0 -> WAIT, counter=1. gnt=1 (regardless of req) -> spurious; stay IDLE.
- WAIT: gnt=1 -> complete: lat_max=max(lat_max,counter), -> IDLE. Else req=0 -> drop, -> IDLE. Else counter==MAX_LAT -> timeout, -> LATE. Else counter+1.
- LATE: gnt=1 or req=0 -> IDLE, no further error; lat_max not updated. Otherwise hold, no repeat timeout.
- gnt and req=0 in same WAIT cycle: completion wins, no drop error.
- Completion cycle ends the transaction; req still high next cycle starts a new request (back-to-back legal, no idle cycle required).
- Latency definition: gnt in the Nth cycle after the first req cycle = latency N; legal range 1..MAX_LAT.
- err_mutex: ONE_HOT_GNT=1 and popcount(gnt)>1; evaluated independently of channel FSMs; tied 0 when ONE_HOT_GNT=0.
- err_count increments by the number of error pulses asserted that cycle (all channels + mutex), saturating at 2^CNT_W-1; no wrap.
- err_sticky = OR of all pulses, held.

## Timing
- Error detected on inputs sampled at edge t -> flag high for exactly one cycle after edge t (registered); err_count/err_sticky/lat_max update at same edge.
- Timeout for request first seen at edge t flags after edge t+MAX_LAT if no gnt sampled on edges t+1..t+MAX_LAT.
- Reset: all FSMs IDLE, counters 0, every output 0; res asserted mid-transaction abandons it with no error reported; checking resumes the cycle after res deasserts.
- No combinational path from inputs to outputs.

## Configuration
- REQ_GNT_CHK_ASSERT_EN defined: additionally compiles named concurrent SVA properties (timeout, spurious, drop, mutex), disabled iff res, each issuing $error with channel index on failure; flag outputs unchanged.
- Undefined: no assertion/simulation-only constructs; flags and counters only (synthesizable for emulation/FPGA debug).

## Test plan
- MAX_LAT=4, ch0 req high edge 0, gnt edge 3 -> no error, lat_max=3, err_count=0.
- ch1 req held, no gnt through edge 4 -> err_timeout[1] single pulse after edge 4, none later; gnt at edge 7 -> no error, lat_max unchanged.
- gnt[2]=1 with ch2 IDLE -> err_spurious[2] pulse, err_sticky=1, err_count=1; ch0 req dropped at latency 2 -> err_drop[0], err_count=2.
- gnt=4'b0101 in one cycle, both channels waiting -> err_mutex pulse, no spurious, err_count+1.
- CNT_W=2, force 5 errors including two simultaneous -> err_count saturates at 3.
- res asserted while ch3 in WAIT for 3 cycles -> all outputs 0, no timeout after release; fresh req completes at latency 1 cleanly.
